// File: rtl/ex_wb_arbiter_pkg.sv
// Shared result payload and default sizing for the execute-stage
// writeback arbiter.
package ex_wb_arbiter_pkg;

   localparam int NUM_FU_DEF   = 4;
   localparam int WB_PORTS_DEF = 2;
   localparam int WB_R_ADDR    = 6;
   localparam int WB_ROB_BITS  = 3;

   typedef struct packed {
      logic [WB_R_ADDR-1:0]   dest;
      logic [31:0]            data;
      logic [WB_ROB_BITS-1:0] ticket;
      logic                   valid_exception;
      logic [3:0]             cause;
      logic                   csr;
   } wb_entry;

endpackage

// File: rtl/fu_result_fifo.sv
// Small in-order result buffer for one functional unit.
// Flush beats push and pop issued in the same cycle.
module fu_result_fifo
   import ex_wb_arbiter_pkg::*;
#(
   parameter int BUF_DEPTH = 2
) (
   input  logic    clk_i,
   input  logic    rst_i,
   input  logic    flush_i,
   input  logic    push_i,
   input  wb_entry data_i,
   input  logic    pop_i,
   output wb_entry head_o,
   output logic    full_o,
   output logic    empty_o
);

   localparam int PW = $clog2(BUF_DEPTH);
   localparam int CW = PW + 1;

   wb_entry       mem_q [BUF_DEPTH];
   logic [PW-1:0] wr_q, wr_d;
   logic [PW-1:0] rd_q, rd_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          do_push;
   logic          do_pop;

   assign full_o  = (cnt_q == CW'(BUF_DEPTH));
   assign empty_o = (cnt_q == '0);
   assign head_o  = mem_q[rd_q];
   assign do_push = push_i & ~full_o;
   assign do_pop  = pop_i & ~empty_o;

   always_comb begin
      wr_d  = wr_q;
      rd_d  = rd_q;
      cnt_d = cnt_q;
      if (flush_i) begin
         wr_d  = '0;
         rd_d  = '0;
         cnt_d = '0;
      end else begin
         if (do_push) wr_d = wr_q + PW'(1);
         if (do_pop)  rd_d = rd_q + PW'(1);
         cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         wr_q  <= wr_d;
         rd_q  <= rd_d;
         cnt_q <= cnt_d;
      end
   end

   // Payload storage needs no reset; count alone defines validity.
   always_ff @(posedge clk_i) begin
      if (do_push && !flush_i) mem_q[wr_q] <= data_i;
   end

endmodule

// File: rtl/ex_wb_arbiter.sv
// Merges per-FU result FIFOs onto registered writeback ports using a
// round-robin multi-grant scan.
module ex_wb_arbiter
   import ex_wb_arbiter_pkg::*;
#(
   parameter int  NUM_FU         = NUM_FU_DEF,
   parameter int  WB_PORTS       = WB_PORTS_DEF,
   parameter int  BUF_DEPTH      = 2,
   parameter int  R_ADDR         = WB_R_ADDR,
   parameter int  ROB_INDEX_BITS = WB_ROB_BITS,
   localparam int FU_W           = $clog2(NUM_FU)
) (
   input  logic                          clk_i,
   input  logic                          rst_i,
   input  logic                          flush_i,
   input  logic [NUM_FU-1:0]             fu_valid_i,
   output logic [NUM_FU-1:0]             fu_ready_o,
   input  wb_entry [NUM_FU-1:0]          fu_data_i,
   output logic [NUM_FU-1:0]             busy_fu_o,
   output logic [WB_PORTS-1:0]           wb_valid_o,
   output wb_entry [WB_PORTS-1:0]        wb_data_o,
   output logic [WB_PORTS-1:0][FU_W-1:0] wb_fu_o,
   output logic                          pending_o
);

   // The payload layout is fixed by the shared package.
   if (R_ADDR != WB_R_ADDR || ROB_INDEX_BITS != WB_ROB_BITS ||
       WB_PORTS < 1 || WB_PORTS > NUM_FU) begin : g_bad_cfg
      $error("ex_wb_arbiter: unsupported parameter set");
   end

   typedef struct packed {
      logic [WB_PORTS-1:0]           gnt;
      logic [WB_PORTS-1:0][FU_W-1:0] idx;
      logic [FU_W-1:0]               nxt;
   } rr_grant_t;

   function automatic rr_grant_t rr_scan(
      input logic [NUM_FU-1:0] req,
      input logic [FU_W-1:0]   ptr
   );
      rr_grant_t g;
      int        n;
      int        f;
      g     = '0;
      g.nxt = ptr;
      n     = 0;
      for (int k = 0; k < NUM_FU; k++) begin
         f = (int'(ptr) + k) % NUM_FU;
         if (req[f] && n < WB_PORTS) begin
            g.gnt[n] = 1'b1;
            g.idx[n] = FU_W'(f);
            g.nxt    = FU_W'((f + 1) % NUM_FU);
            n++;
         end
      end
      return g;
   endfunction

   wb_entry                       head [NUM_FU];
   logic [NUM_FU-1:0]             full;
   logic [NUM_FU-1:0]             empty;
   logic [NUM_FU-1:0]             push;
   logic [NUM_FU-1:0]             pop;
   rr_grant_t                     grant;
   logic [FU_W-1:0]               rr_q, rr_d;
   logic [WB_PORTS-1:0]           wb_valid_q, wb_valid_d;
   wb_entry [WB_PORTS-1:0]        wb_data_q, wb_data_d;
   logic [WB_PORTS-1:0][FU_W-1:0] wb_fu_q, wb_fu_d;

   assign push  = fu_valid_i & ~full;
   assign grant = rr_scan(~empty, rr_q);

   for (genvar i = 0; i < NUM_FU; i++) begin : g_fifo
      fu_result_fifo #(
         .BUF_DEPTH (BUF_DEPTH)
      ) u_fifo (
         .clk_i   (clk_i),
         .rst_i   (rst_i),
         .flush_i (flush_i),
         .push_i  (push[i]),
         .data_i  (fu_data_i[i]),
         .pop_i   (pop[i]),
         .head_o  (head[i]),
         .full_o  (full[i]),
         .empty_o (empty[i])
      );
   end

   always_comb begin
      pop        = '0;
      rr_d       = grant.nxt;
      wb_valid_d = grant.gnt;
      wb_data_d  = wb_data_q;
      wb_fu_d    = wb_fu_q;
      for (int p = 0; p < WB_PORTS; p++) begin
         if (grant.gnt[p]) begin
            pop[grant.idx[p]] = 1'b1;
            wb_data_d[p]      = head[grant.idx[p]];
            wb_fu_d[p]        = grant.idx[p];
         end
      end
      // Redirect drops in-flight results but keeps fairness state.
      if (flush_i) begin
         rr_d       = rr_q;
         wb_valid_d = '0;
         wb_data_d  = wb_data_q;
         wb_fu_d    = wb_fu_q;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rr_q       <= '0;
         wb_valid_q <= '0;
         wb_data_q  <= '0;
         wb_fu_q    <= '0;
      end else begin
         rr_q       <= rr_d;
         wb_valid_q <= wb_valid_d;
         wb_data_q  <= wb_data_d;
         wb_fu_q    <= wb_fu_d;
      end
   end

   assign fu_ready_o = ~full;
   assign busy_fu_o  = full;
   assign wb_valid_o = wb_valid_q;
   assign wb_data_o  = wb_data_q;
   assign wb_fu_o    = wb_fu_q;
   assign pending_o  = ~&empty;

endmodule

// File: tb/tb_ex_wb_arbiter.sv
// Scoreboard bench: directed pushes queue expected writebacks,
// per-DUT monitors pop and compare on every wb_valid.
module tb_ex_wb_arbiter;
   import ex_wb_arbiter_pkg::*;

   typedef struct {
      int      port;
      int      fu;
      wb_entry e;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int   checks = 0;
   int   errors = 0;
   exp_t qa[$];
   exp_t qb[$];

   logic                rst_a, flush_a;
   logic [3:0]          v_a, rdy_a, busy_a;
   wb_entry [3:0]       d_a;
   logic [1:0]          wv_a;
   wb_entry [1:0]       wd_a;
   logic [1:0][1:0]     wf_a;
   logic                pend_a;

   logic                rst_b, flush_b;
   logic [3:0]          v_b, rdy_b, busy_b;
   wb_entry [3:0]       d_b;
   logic [0:0]          wv_b;
   wb_entry [0:0]       wd_b;
   logic [0:0][1:0]     wf_b;
   logic                pend_b;

   ex_wb_arbiter #(.NUM_FU(4), .WB_PORTS(2)) u_a (
      .clk_i      (clk),
      .rst_i      (rst_a),
      .flush_i    (flush_a),
      .fu_valid_i (v_a),
      .fu_ready_o (rdy_a),
      .fu_data_i  (d_a),
      .busy_fu_o  (busy_a),
      .wb_valid_o (wv_a),
      .wb_data_o  (wd_a),
      .wb_fu_o    (wf_a),
      .pending_o  (pend_a)
   );

   ex_wb_arbiter #(.NUM_FU(4), .WB_PORTS(1)) u_b (
      .clk_i      (clk),
      .rst_i      (rst_b),
      .flush_i    (flush_b),
      .fu_valid_i (v_b),
      .fu_ready_o (rdy_b),
      .fu_data_i  (d_b),
      .busy_fu_o  (busy_b),
      .wb_valid_o (wv_b),
      .wb_data_o  (wd_b),
      .wb_fu_o    (wf_b),
      .pending_o  (pend_b)
   );

   function automatic wb_entry mk(input int f, input int k);
      wb_entry e;
      e        = '0;
      e.dest   = 6'(f * 8 + k);
      e.data   = 32'hA000_0000 | 32'(f << 8) | 32'(k);
      e.ticket = 3'(k);
      return e;
   endfunction

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic exp_a(input int p, input int f, input wb_entry e);
      qa.push_back('{port: p, fu: f, e: e});
   endtask

   task automatic exp_b(input int f, input wb_entry e);
      qb.push_back('{port: 0, fu: f, e: e});
   endtask

   always @(negedge clk) begin
      exp_t x;
      for (int p = 0; p < 2; p++) begin
         if (wv_a[p]) begin
            checks++;
            if (qa.size() == 0) begin
               errors++;
               $display("FAIL monA_unexpected port %0d fu %0d dest %0d",
                        p, wf_a[p], wd_a[p].dest);
            end else begin
               x = qa.pop_front();
               if (x.port != p || x.fu != int'(wf_a[p]) || x.e != wd_a[p]) begin
                  errors++;
                  $display("FAIL monA port %0d got fu %0d dest %0d data %h, expected port %0d fu %0d dest %0d data %h",
                           p, wf_a[p], wd_a[p].dest, wd_a[p].data,
                           x.port, x.fu, x.e.dest, x.e.data);
               end
            end
         end
      end
   end

   always @(negedge clk) begin
      exp_t y;
      if (wv_b[0]) begin
         checks++;
         if (qb.size() == 0) begin
            errors++;
            $display("FAIL monB_unexpected fu %0d dest %0d",
                     wf_b[0], wd_b[0].dest);
         end else begin
            y = qb.pop_front();
            if (y.fu != int'(wf_b[0]) || y.e != wd_b[0]) begin
               errors++;
               $display("FAIL monB got fu %0d dest %0d data %h, expected fu %0d dest %0d data %h",
                        wf_b[0], wd_b[0].dest, wd_b[0].data,
                        y.fu, y.e.dest, y.e.data);
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic rst_pulse_a();
      rst_a = 1'b1;
      step();
      rst_a = 1'b0;
   endtask

   task automatic rst_pulse_b();
      rst_b = 1'b1;
      step();
      rst_b = 1'b0;
   endtask

   task automatic cyc_a(input logic [3:0] m, input logic fl, input int k);
      v_a     = m;
      flush_a = fl;
      for (int f = 0; f < 4; f++) d_a[f] = mk(f, k);
      step();
      v_a     = '0;
      flush_a = 1'b0;
   endtask

   task automatic drain_a();
      for (int i = 0; i < 20 && qa.size() != 0; i++) step();
      chk("drainA", 64'(qa.size()), 64'd0);
      step();
      step();
   endtask

   task automatic drain_b();
      for (int i = 0; i < 40 && qb.size() != 0; i++) step();
      chk("drainB", 64'(qb.size()), 64'd0);
      step();
      chk("drainB_pending", 64'(pend_b), 64'd0);
   endtask

   task automatic stream_b(input int n0, input int n1, input int n2,
                           input int n3, input bit bp);
      int         n   [4];
      int         idx [4];
      logic [3:0] acc;
      bit         done;
      n    = '{n0, n1, n2, n3};
      idx  = '{0, 0, 0, 0};
      done = 1'b0;
      for (int c = 0; c < 60 && !done; c++) begin
         for (int f = 0; f < 4; f++) begin
            v_b[f] = (idx[f] < n[f]);
            d_b[f] = mk(f, idx[f]);
         end
         acc = v_b & rdy_b;
         step();
         for (int f = 0; f < 4; f++) if (acc[f]) idx[f]++;
         if (bp && c == 1) begin
            chk("bp_ready_low", 64'(rdy_b[1]), 64'd0);
            chk("bp_busy_high", 64'(busy_b[1]), 64'd1);
         end
         if (bp && c == 2) chk("bp_ready_after_pop", 64'(rdy_b[1]), 64'd1);
         done = 1'b1;
         for (int f = 0; f < 4; f++) if (idx[f] != n[f]) done = 1'b0;
      end
      v_b = '0;
      chk("streamB_done", 64'(done), 64'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

   initial begin
      wb_entry es;
      rst_a = 1'b1; flush_a = 1'b0; v_a = '0; d_a = '0;
      rst_b = 1'b1; flush_b = 1'b0; v_b = '0; d_b = '0;
      step();
      step();
      rst_a = 1'b0;
      rst_b = 1'b0;

      chk("rst_wb_valid", 64'(wv_a), 64'd0);
      chk("rst_wb_data_zero", 64'(wd_a == '0), 64'd1);
      chk("rst_wb_fu", 64'(wf_a), 64'd0);
      chk("rst_ready", 64'(rdy_a), 64'hF);
      chk("rst_busy", 64'(busy_a), 64'd0);
      chk("rst_pending", 64'(pend_a), 64'd0);

      // single result from FU2
      es      = '0;
      es.dest = 6'd5;
      es.data = 32'hDEAD_BEEF;
      exp_a(0, 2, es);
      v_a     = 4'b0100;
      d_a[2]  = es;
      step();
      v_a     = '0;
      chk("single_pending", 64'(pend_a), 64'd1);
      chk("single_not_yet", 64'(wv_a), 64'd0);
      step();
      chk("single_wbv", 64'(wv_a), 64'b01);
      chk("single_wbfu", 64'(wf_a[0]), 64'd2);
      chk("single_dest", 64'(wd_a[0].dest), 64'd5);
      chk("single_pend_clr", 64'(pend_a), 64'd0);
      drain_a();

      // contention: all four push with rr_ptr at 0
      rst_pulse_a();
      exp_a(0, 0, mk(0, 1));
      exp_a(1, 1, mk(1, 1));
      exp_a(0, 2, mk(2, 1));
      exp_a(1, 3, mk(3, 1));
      cyc_a(4'hF, 1'b0, 1);
      step();
      chk("cont_wbv1", 64'(wv_a), 64'b11);
      chk("cont_pend1", 64'(pend_a), 64'd1);
      step();
      chk("cont_wbv2", 64'(wv_a), 64'b11);
      chk("cont_pend2", 64'(pend_a), 64'd0);
      drain_a();
      // rr_ptr back at 0: FU1 wins port 0 over FU3
      exp_a(0, 1, mk(1, 5));
      exp_a(1, 3, mk(3, 5));
      cyc_a(4'b1010, 1'b0, 5);
      drain_a();

      // flush with five entries buffered and FU3 pushing
      rst_pulse_a();
      exp_a(0, 0, mk(0, 0));
      exp_a(1, 1, mk(1, 0));
      cyc_a(4'hF, 1'b0, 0);
      cyc_a(4'b0111, 1'b0, 1);
      chk("flush_pre_pending", 64'(pend_a), 64'd1);
      cyc_a(4'b1000, 1'b1, 9);
      chk("flush_pending", 64'(pend_a), 64'd0);
      chk("flush_wbv", 64'(wv_a), 64'd0);
      chk("flush_ready", 64'(rdy_a), 64'hF);
      repeat (4) step();
      chk("flush_stays_empty", 64'(pend_a), 64'd0);
      // rr_ptr kept at 2 across flush: FU3 ahead of FU1
      exp_a(0, 3, mk(3, 6));
      exp_a(1, 1, mk(1, 6));
      cyc_a(4'b1010, 1'b0, 6);
      drain_a();

      // reset while both ports are valid
      rst_pulse_a();
      exp_a(0, 0, mk(0, 2));
      exp_a(1, 1, mk(1, 2));
      cyc_a(4'hF, 1'b0, 2);
      step();
      chk("rtr_wbv_before", 64'(wv_a), 64'b11);
      rst_pulse_a();
      chk("rtr_wbv", 64'(wv_a), 64'd0);
      chk("rtr_wb_data_zero", 64'(wd_a == '0), 64'd1);
      chk("rtr_wb_fu", 64'(wf_a), 64'd0);
      chk("rtr_pending", 64'(pend_a), 64'd0);
      chk("rtr_ready", 64'(rdy_a), 64'hF);
      chk("rtr_busy", 64'(busy_a), 64'd0);
      exp_a(0, 1, mk(1, 7));
      exp_a(1, 3, mk(3, 7));
      cyc_a(4'b1010, 1'b0, 7);
      drain_a();

      // backpressure on FU1 while FU0 floods, single port
      rst_pulse_b();
      exp_b(0, mk(0, 0));
      exp_b(1, mk(1, 0));
      exp_b(0, mk(0, 1));
      exp_b(1, mk(1, 1));
      exp_b(0, mk(0, 2));
      exp_b(1, mk(1, 2));
      exp_b(0, mk(0, 3));
      exp_b(0, mk(0, 4));
      stream_b(5, 3, 0, 0, 1'b1);
      drain_b();

      // rotation fairness between FU0 and FU3
      rst_pulse_b();
      for (int k = 0; k < 6; k++) begin
         exp_b(0, mk(0, k));
         exp_b(3, mk(3, k));
      end
      stream_b(6, 0, 0, 6, 1'b0);
      drain_b();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/ex_wb_arbiter.md
# ex_wb_arbiter

Parametrised writeback arbiter for the scalar execute stage. It takes results from NUM_FU functional units (LSU, CSR, ALU, BRU and further units), buffers each unit's results in a small in-order FIFO, and merges them onto WB_PORTS registered writeback ports. Arbitration is round-robin. Per-unit backpressure replaces today's fixed one-result-per-unit-per-cycle update bus, and a flush clears all buffered results on redirect.

## Interface
Parameters:
- NUM_FU, 4: number of functional-unit result channels (≥2).
- WB_PORTS, 2: number of writeback ports (1..NUM_FU).
- BUF_DEPTH, 2: entries per FU FIFO (power of two, ≥2).
- R_ADDR, 6: destination register address width.
- ROB_INDEX_BITS, 3: ROB ticket width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- flush  in  1  discard all buffered and in-flight results.
- fu_valid  in  NUM_FU  per-FU result valid.
- fu_ready  out  NUM_FU  per-FU accept; handshake completes when fu_valid[i] & fu_ready[i].
- fu_data  in  NUM_FU × wb_entry  per-FU result payload.
- busy_fu  out  NUM_FU  equals ~fu_ready; feeds issue-queue stall.
- wb_valid  out  WB_PORTS  writeback port valid (registered).
- wb_data  out  WB_PORTS × wb_entry  writeback payload (registered).
- wb_fu  out  WB_PORTS × clog2(NUM_FU)  source FU index of each port.
- pending  out  1  any FIFO non-empty.

## Operation
- **Push.** FU i pushes when fu_valid[i] & fu_ready[i]. fu_ready[i] = (count[i] != BUF_DEPTH), computed from the registered count only. A full FIFO does not accept in a cycle where it pops.
- **Per-FU order.** Results leave in arrival order; at most one pop per FU per cycle.
- **Arbitration.** Each cycle, scan FUs starting at rr_ptr, upward mod NUM_FU. Grant the first WB_PORTS FUs with non-empty FIFOs; port 0 gets the first grant, port 1 the second, and so on. Ungranted ports drive wb_valid=0.
- **Pointer update.** If any grant occurred, rr_ptr ← (last granted index + 1) mod NUM_FU; otherwise it holds.
- **Pop.** A granted FIFO pops its head. Its head payload and index are registered onto the granted port.
- **Flush.** Flush has priority over push and pop in the same cycle. On the next edge all counts and pointers clear, wb_valid ← 0, and any push offered in the flush cycle is dropped. rr_ptr is unchanged.
- **Counters.** Counts are clog2(BUF_DEPTH)+1 bits wide. Read and write pointers are clog2(BUF_DEPTH) bits and wrap naturally.
- **Reset values.** wb_valid=0, wb_data=0, wb_fu=0, rr_ptr=0, all counts 0. Hence fu_ready all 1, busy_fu all 0, pending=0.

## Timing
- Push at edge N makes the entry head-visible in cycle N+1. If granted in N+1, it appears on wb_* in cycle N+2 (2-cycle latency, empty FIFO, no contention).
- A FIFO that is full at edge N and pops at edge N shows fu_ready=1 in cycle N+1.
- Sustained throughput is min(NUM_FU, WB_PORTS) results/cycle, with at most one per FU.
- With BUF_DEPTH=2, FU i can stream one result per cycle only while it is granted every cycle.
- No downstream backpressure: wb_valid is a single-cycle pulse and the consumer must take it.
- Reset in mid-operation behaves as flush and also clears wb_* and rr_ptr.

## Structure
- The shared package holds:
  - typedef wb_entry: dest [R_ADDR-1:0], data [31:0], ticket [ROB_INDEX_BITS-1:0], valid_exception, cause [3:0], csr.
  - The default NUM_FU/WB_PORTS constants.
- One sub-module, fu_result_fifo: BUF_DEPTH, wb_entry storage, push/pop/flush, count, full/empty. Instantiated NUM_FU times in a generate loop.
- The round-robin multi-grant scan is a combinational function in ex_wb_arbiter.

## Test plan
- **Single result.** Reset, then push FU2 one entry (dest=5, data=0xDEADBEEF) at edge 1 → wb_valid[0]=1 in cycle 3 with dest 5, wb_fu[0]=2; wb_valid[1]=0.
- **Contention.** All 4 FUs push simultaneously with WB_PORTS=2, rr_ptr=0 → cycle N+2: ports carry FU0 and FU1; cycle N+3: FU2 and FU3; rr_ptr returns to 0.
- **Backpressure.** FU1 pushes 3 consecutive results while FU0 floods and hogs grants (WB_PORTS=1) → fu_ready[1]=0 after 2 accepted; the third is held until a pop; FU1 output order is preserved.
- **Flush.** Flush with FIFOs holding 5 entries total while FU3 pushes in the same cycle → next cycle pending=0, wb_valid=0, fu_ready all 1; the FU3 entry never appears.
- **Rotation fairness.** FU0 and FU3 are continuously valid with WB_PORTS=1 → grants alternate FU0, FU3, FU0, …; neither waits more than 1 cycle.
- **Reset during traffic.** Assert rst while wb_valid=2'b11 → next cycle all outputs are at their reset values, with rr_ptr=0.
